// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, runs the imem req/ack handshake, and absorbs stalls and redirects.
module fetch_stage #(
    parameter int unsigned     PC_W       = 32,
    parameter int unsigned     INST_W     = 32,
    parameter int unsigned     ADDR_RFILE = 5,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_ctrl,
    input  logic                  redirect,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_W-1:0]     imem_rdata,
    output logic [PC_W-1:0]       pc_ifid,
    output logic [INST_W-1:0]     inst_ifid,
    output logic                  valid_ifid,
    output logic [ADDR_RFILE-1:0] addr_rs_ifid,
    output logic [ADDR_RFILE-1:0] addr_rt_ifid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_target;
    logic [INST_W-1:0] r_skid;
    logic [PC_W-1:0]   r_pc_ifid;
    logic [INST_W-1:0] r_inst_ifid;
    logic              r_valid_ifid;

    logic              w_redir;
    logic              w_ack;
    logic              w_deliver;
    logic [INST_W-1:0] w_dinst;
    logic [PC_W-1:0]   w_pc_inc;

    // A stalled branch in ID cannot redirect; ack only counts while requesting.
    assign w_redir  = redirect & ~stall_ctrl;
    assign w_ack    = imem_ack & r_req;
    assign w_pc_inc = r_pc + PC_W'(4);

    always_comb begin
        w_deliver = 1'b0;
        w_dinst   = imem_rdata;
        case (r_state)
            S_REQ:  w_deliver = w_ack & ~stall_ctrl & ~redirect;
            S_HOLD: begin
                w_deliver = ~stall_ctrl & ~redirect;
                w_dinst   = r_skid;
            end
            default: w_deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_skid   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (w_ack) begin
                        if (w_redir) begin
                            r_pc <= redirect_pc;
                        end else if (stall_ctrl) begin
                            r_skid  <= imem_rdata;
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end else if (w_redir) begin
                        r_target <= redirect_pc;
                        r_state  <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else if (!stall_ctrl) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_DROP: begin
                    // Address must stay put until the stale fetch is acked.
                    if (w_ack) begin
                        r_pc    <= w_redir ? redirect_pc : r_target;
                        r_state <= S_REQ;
                    end else if (w_redir) begin
                        r_target <= redirect_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_ifid    <= '0;
            r_inst_ifid  <= '0;
            r_valid_ifid <= 1'b0;
        end else if (!stall_ctrl) begin
            if (w_deliver) begin
                r_pc_ifid    <= r_pc;
                r_inst_ifid  <= w_dinst;
                r_valid_ifid <= 1'b1;
            end else begin
                r_inst_ifid  <= '0;
                r_valid_ifid <= 1'b0;
            end
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign pc_ifid      = r_pc_ifid;
    assign inst_ifid    = r_inst_ifid;
    assign valid_ifid   = r_valid_ifid;
    assign addr_rs_ifid = r_inst_ifid[25:21];
    assign addr_rt_ifid = r_inst_ifid[20:16];

endmodule
